// File: rtl/rat_recovery_ctrl_if.sv
// Bundle of the flush request, ROB read port and RAT restore signals around the recovery controller.
// slave is the controller's view; master is the surrounding commit/ROB/RAT view.
interface rat_recovery_ctrl_if #(
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int ROB_ID_WIDTH     = 5
);
    logic                        flush_req;
    logic                        flush_req_ready;
    logic [ROB_ID_WIDTH-1:0]     flush_rob_id;
    logic [ROB_ID_WIDTH-1:0]     flush_rob_tail_id;
    logic                        flush_rob_full;
    logic                        busy;
    logic                        flush_ack;
    logic [ROB_ID_WIDTH-1:0]     rctrl_rob_read_id;
    logic                        rctrl_rob_read_valid;
    logic                        rob_rctrl_has_dst;
    logic [PHY_REG_ID_WIDTH-1:0] rob_rctrl_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] rob_rctrl_old_phy_id;
    logic                        commit_rat_restore_map;
    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id;
    logic [1:0]                  state_dbg;

    // Handshake: a flush is taken on any clock edge where flush_req && flush_req_ready;
    // a request seen while not ready is dropped, never queued. flush_ack pulses once per accepted flush.
    modport slave (
        input  flush_req, flush_rob_id, flush_rob_tail_id, flush_rob_full,
        input  rob_rctrl_has_dst, rob_rctrl_new_phy_id, rob_rctrl_old_phy_id,
        output flush_req_ready, busy, flush_ack,
        output rctrl_rob_read_id, rctrl_rob_read_valid,
        output commit_rat_restore_map, commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id,
        output state_dbg
    );

    modport master (
        output flush_req, flush_rob_id, flush_rob_tail_id, flush_rob_full,
        output rob_rctrl_has_dst, rob_rctrl_new_phy_id, rob_rctrl_old_phy_id,
        input  flush_req_ready, busy, flush_ack,
        input  rctrl_rob_read_id, rctrl_rob_read_valid,
        input  commit_rat_restore_map, commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id,
        input  state_dbg
    );
endinterface

// File: rtl/rat_recovery_ctrl.sv
// RAT rollback sequencer: walks squashed ROB entries youngest-to-oldest, one per cycle,
// and turns each returned entry into a restore_map on the RAT while holding rename stalled.
module rat_recovery_ctrl #(
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int ROB_ID_WIDTH     = 5
) (
    input logic               clk,
    input logic               rst,
    rat_recovery_ctrl_if.slave rr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ROB_ID_WIDTH:0] CNT_ONE  = (ROB_ID_WIDTH+1)'(1);
    localparam logic [ROB_ID_WIDTH:0] CNT_FULL = {1'b1, {ROB_ID_WIDTH{1'b0}}};

    state_t                  state;
    logic [ROB_ID_WIDTH-1:0] ptr;
    logic [ROB_ID_WIDTH:0]   remaining;
    logic                    read_valid_q;
    logic                    rd_pending;
    logic                    ack_q;

    logic [ROB_ID_WIDTH-1:0] span;
    logic [ROB_ID_WIDTH:0]   walk_cnt;
    logic                    accept;
    logic                    restore;

    // tail == oldest squashed id means either nothing to undo or the whole ROB; full picks which.
    always_comb begin
        span     = rr.flush_rob_tail_id - rr.flush_rob_id;
        walk_cnt = {1'b0, span};
        if ((span == '0) && rr.flush_rob_full) begin
            walk_cnt = CNT_FULL;
        end
    end

    assign accept = rr.flush_req && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            remaining    <= '0;
            read_valid_q <= 1'b0;
            rd_pending   <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            rd_pending <= read_valid_q;
            ack_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remaining <= walk_cnt;
                        if (walk_cnt != '0) begin
                            state        <= S_WALK;
                            ptr          <= rr.flush_rob_tail_id - 1'b1;
                            read_valid_q <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            ack_q <= 1'b1;
                        end
                    end
                end
                // ptr/remaining describe the read on the bus this cycle; advance to the next older entry.
                S_WALK: begin
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state        <= S_DRAIN;
                        read_valid_q <= 1'b0;
                    end else begin
                        ptr <= ptr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    ack_q <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Entry without a real destination (no dst, or the hardwired-zero reg) consumes its slot silently.
    assign restore = rd_pending && rr.rob_rctrl_has_dst && (rr.rob_rctrl_new_phy_id != '0);

    assign rr.commit_rat_restore_map        = restore;
    assign rr.commit_rat_restore_new_phy_id = restore ? rr.rob_rctrl_new_phy_id : '0;
    assign rr.commit_rat_restore_old_phy_id = restore ? rr.rob_rctrl_old_phy_id : '0;

    assign rr.busy                 = (state != S_IDLE);
    assign rr.flush_req_ready      = (state == S_IDLE);
    assign rr.flush_ack            = ack_q;
    assign rr.rctrl_rob_read_valid = read_valid_q;
    assign rr.rctrl_rob_read_id    = ptr;
    assign rr.state_dbg            = state;

    a_read_only_in_walk: assert property (@(posedge clk) disable iff (rst)
        read_valid_q == (state == S_WALK));

    a_walk_has_work: assert property (@(posedge clk) disable iff (rst)
        (state == S_WALK) |-> (remaining != '0));

    a_ack_only_in_done: assert property (@(posedge clk) disable iff (rst)
        ack_q == (state == S_DONE));

endmodule
